// File: rtl/jtcps_raster_multi.sv
// rtl/jtcps_raster_multi.sv - multi-line raster interrupt unit with NLINE line counters and one pixel counter
module jtcps_raster_multi #(
    parameter int NLINE = 2,
    parameter int CW    = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pxl_cen,
    input  logic             frame_start,
    input  logic             line_inc,
    input  logic [NLINE:0]   cnt_sel,
    input  logic             wrn,
    input  logic [15:0]      cpu_dout,
    input  logic             irq_ack,
    output logic [CW-1:0]    cnt_dout,
    output logic [NLINE-1:0] irq_src,
    output logic             raster
);

    logic [NLINE-1:0][CW-1:0] line_cnt_q, line_cnt_d;
    logic [NLINE-1:0][CW-1:0] line_start_q, line_start_d;
    logic [NLINE-1:0]         one_shot_q, one_shot_d;
    logic [NLINE-1:0]         enable_q, enable_d;
    logic [CW-1:0]            pxl_cnt_q, pxl_cnt_d;
    logic [CW-1:0]            pxl_start_q, pxl_start_d;
    logic                     pxl_done_q, pxl_done_d;
    logic [NLINE-1:0]         irq_src_q, irq_src_d;
    logic                     raster_q, raster_d;
    logic [CW-1:0]            cnt_dout_q, cnt_dout_d;

    logic             step;
    logic             restart;
    logic             cpu_wr;
    logic             pxlhit;
    logic             rd_found;
    logic [NLINE-1:0] lzero;
    logic [NLINE-1:0] hit;
    logic             unused_cpu_bits;

    assign unused_cpu_bits = ^cpu_dout;

    always_comb begin
        step    = pxl_cen & line_inc;
        restart = step & frame_start;
        cpu_wr  = ~wrn;

        line_cnt_d   = line_cnt_q;
        line_start_d = line_start_q;
        one_shot_d   = one_shot_q;
        enable_d     = enable_q;
        lzero        = '0;

        for (int i = 0; i < NLINE; i++) begin
            lzero[i] = (line_cnt_q[i] == '0);
            if (step) begin
                if (restart)
                    line_cnt_d[i] = line_start_q[i];
                else if (lzero[i] && one_shot_q[i])
                    line_cnt_d[i] = '0;
                else
                    line_cnt_d[i] = line_cnt_q[i] - CW'(1);
            end
            // An immediate CPU load takes priority over a coincident step
            if (cpu_wr && cnt_sel[i]) begin
                line_start_d[i] = cpu_dout[CW-1:0];
                one_shot_d[i]   = cpu_dout[14];
                enable_d[i]     = cpu_dout[13];
                if (cpu_dout[15])
                    line_cnt_d[i] = cpu_dout[CW-1:0];
            end
        end

        pxlhit      = pxl_cen & ~step & (pxl_cnt_q == '0) & ~pxl_done_q;
        pxl_cnt_d   = pxl_cnt_q;
        pxl_done_d  = pxl_done_q;
        pxl_start_d = pxl_start_q;
        if (step) begin
            pxl_cnt_d  = pxl_start_q;
            pxl_done_d = 1'b0;
        end else if (pxl_cen && (pxl_cnt_q != '0)) begin
            pxl_cnt_d = pxl_cnt_q - CW'(1);
        end
        // done guarantees a single pixel hit per line even while the count sits at zero
        if (pxlhit)
            pxl_done_d = 1'b1;
        if (cpu_wr && cnt_sel[NLINE])
            pxl_start_d = cpu_dout[CW-1:0];

        hit       = {NLINE{pxlhit}} & lzero & enable_q;
        irq_src_d = (irq_src_q & ~{NLINE{irq_ack}}) | hit;
        raster_d  = |irq_src_q;

        cnt_dout_d = cnt_dout_q;
        rd_found   = 1'b0;
        for (int i = 0; i < NLINE; i++) begin
            if (!rd_found && cnt_sel[i]) begin
                cnt_dout_d = line_cnt_q[i];
                rd_found   = 1'b1;
            end
        end
        if (!rd_found && cnt_sel[NLINE])
            cnt_dout_d = pxl_cnt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_cnt_q   <= '1;
            line_start_q <= '1;
            one_shot_q   <= '0;
            enable_q     <= '1;
            pxl_cnt_q    <= '1;
            pxl_start_q  <= '1;
            pxl_done_q   <= 1'b0;
            irq_src_q    <= '0;
            raster_q     <= 1'b0;
            cnt_dout_q   <= '1;
        end else begin
            line_cnt_q   <= line_cnt_d;
            line_start_q <= line_start_d;
            one_shot_q   <= one_shot_d;
            enable_q     <= enable_d;
            pxl_cnt_q    <= pxl_cnt_d;
            pxl_start_q  <= pxl_start_d;
            pxl_done_q   <= pxl_done_d;
            irq_src_q    <= irq_src_d;
            raster_q     <= raster_d;
            cnt_dout_q   <= cnt_dout_d;
        end
    end

    assign cnt_dout = cnt_dout_q;
    assign irq_src  = irq_src_q;
    assign raster   = raster_q;

endmodule

// File: tb/tb_jtcps_raster_multi.sv
// tb/tb_jtcps_raster_multi.sv - scoreboard bench for jtcps_raster_multi
module tb_jtcps_raster_multi;
    localparam int NLINE = 2;
    localparam int CW    = 9;

    logic             clk;
    logic             rst;
    logic             pxl_cen;
    logic             frame_start;
    logic             line_inc;
    logic [NLINE:0]   cnt_sel;
    logic             wrn;
    logic [15:0]      cpu_dout;
    logic             irq_ack;
    logic [CW-1:0]    cnt_dout;
    logic [NLINE-1:0] irq_src;
    logic             raster;

    jtcps_raster_multi #(.NLINE(NLINE), .CW(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .pxl_cen     (pxl_cen),
        .frame_start (frame_start),
        .line_inc    (line_inc),
        .cnt_sel     (cnt_sel),
        .wrn         (wrn),
        .cpu_dout    (cpu_dout),
        .irq_ack     (irq_ack),
        .cnt_dout    (cnt_dout),
        .irq_src     (irq_src),
        .raster      (raster)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [NLINE-1:0] exp_src_q[$];
    logic             exp_ras_q[$];
    logic [CW-1:0]    exp_rd_q[$];
    logic             rd_req = 1'b0;
    logic             rd_vld = 1'b0;
    logic             mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) rd_vld <= rd_req;

    // Monitor: readback is a one-clk-latency transaction, irq_src/raster changes are events
    initial begin
        logic [NLINE-1:0] prev_src;
        logic [NLINE-1:0] last_src;
        logic             prev_ras;
        logic             last_rst;
        wait (mon_en);
        prev_src = irq_src;
        last_src = irq_src;
        prev_ras = raster;
        last_rst = rst;
        forever begin
            @(negedge clk);
            if (rd_vld) begin
                if (exp_rd_q.size() == 0) chk("readback_unexpected", 32'(cnt_dout), 32'hFFFF);
                else                      chk("readback", 32'(cnt_dout), 32'(exp_rd_q.pop_front()));
            end
            if (irq_src !== prev_src) begin
                if (exp_src_q.size() == 0) chk("irq_src_unexpected", 32'(irq_src), 32'(prev_src));
                else                       chk("irq_src", 32'(irq_src), 32'(exp_src_q.pop_front()));
                prev_src = irq_src;
            end
            if (raster !== prev_ras) begin
                if (exp_ras_q.size() == 0) chk("raster_unexpected", 32'(raster), 32'(prev_ras));
                else                       chk("raster", 32'(raster), 32'(exp_ras_q.pop_front()));
                if (!rst && !last_rst) chk("raster_lag", 32'(raster), 32'(|last_src));
                prev_ras = raster;
            end
            last_src = irq_src;
            last_rst = rst;
        end
    end

    task automatic cyc(input logic pxl, input logic ln, input logic fr, input logic wr,
                       input logic [NLINE:0] sel, input logic [15:0] d,
                       input logic ack, input logic rd);
        pxl_cen = pxl; line_inc = ln; frame_start = fr; wrn = ~wr;
        cnt_sel = sel; cpu_dout = d; irq_ack = ack; rd_req = rd;
        @(posedge clk);
        #1;
        pxl_cen = 1'b0; line_inc = 1'b0; frame_start = 1'b0; wrn = 1'b1;
        cnt_sel = '0; cpu_dout = '0; irq_ack = 1'b0; rd_req = 1'b0;
    endtask

    task automatic wr_reg(input logic [NLINE:0] sel, input logic [15:0] d);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, sel, d, 1'b0, 1'b0);
    endtask

    task automatic rd_reg(input logic [NLINE:0] sel, input logic [CW-1:0] exp);
        exp_rd_q.push_back(exp);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, sel, 16'h0, 1'b0, 1'b1);
    endtask

    task automatic step_cyc(input logic fr);
        cyc(1'b1, 1'b1, fr, 1'b0, '0, 16'h0, 1'b0, 1'b0);
    endtask

    task automatic body(input int len, input int ack_a, input int ack_b);
        for (int i = 1; i <= len; i++)
            cyc(1'b1, 1'b0, 1'b0, 1'b0, '0, 16'h0, (i == ack_a) || (i == ack_b), 1'b0);
    endtask

    task automatic run_line(input logic fr, input int len, input int ack_a, input int ack_b);
        step_cyc(fr);
        body(len, ack_a, ack_b);
    endtask

    task automatic exp_irq(input logic [NLINE-1:0] src);
        exp_src_q.push_back(src);
        exp_ras_q.push_back(|src);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        rst = 1'b1; pxl_cen = 1'b0; frame_start = 1'b0; line_inc = 1'b0;
        cnt_sel = '0; wrn = 1'b1; cpu_dout = '0; irq_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_cnt_dout", 32'(cnt_dout), 32'h1FF);
        chk("reset_irq_src", 32'(irq_src), 32'h0);
        chk("reset_raster", 32'(raster), 32'h0);
        mon_en = 1'b1;

        // Deferred programming, frame restart, hit after 5 steps and 11 pixels
        rd_reg(3'b001, 9'h1FF);
        rd_reg(3'b100, 9'h1FF);
        wr_reg(3'b001, 16'h2005);
        wr_reg(3'b100, 16'h000A);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, '0, 16'h0, 1'b0, 1'b0);
        rd_reg(3'b001, 9'h1FF);
        step_cyc(1'b1);
        rd_reg(3'b100, 9'd10);
        rd_reg(3'b011, 9'd5);
        body(16, 0, 0);
        repeat (4) run_line(1'b0, 16, 0, 0);
        exp_irq(2'b01);
        exp_irq(2'b00);
        run_line(1'b0, 16, 13, 0);

        // Immediate loads, write beats step, enable mask, hit coincident with ack
        step_cyc(1'b0);
        body(14, 0, 0);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 3'b001, 16'h8004, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 3'b010, 16'hA003, 1'b0, 1'b0);
        rd_reg(3'b001, 9'd3);
        rd_reg(3'b110, 9'd3);
        body(16, 0, 0);
        repeat (2) run_line(1'b0, 16, 0, 0);
        exp_irq(2'b10);
        exp_irq(2'b00);
        run_line(1'b0, 16, 11, 12);

        // One-shot line holds zero: one hit per line
        wr_reg(3'b001, 16'h6001);
        wr_reg(3'b010, 16'h01FF);
        run_line(1'b1, 16, 0, 0);
        repeat (3) begin
            exp_irq(2'b01);
            exp_irq(2'b00);
            run_line(1'b0, 16, 13, 0);
        end
        rd_reg(3'b001, 9'd0);

        // Free-running line wraps past zero: single hit
        wr_reg(3'b001, 16'h2001);
        run_line(1'b1, 16, 0, 0);
        exp_irq(2'b01);
        exp_irq(2'b00);
        run_line(1'b0, 16, 13, 0);
        repeat (2) run_line(1'b0, 16, 0, 0);
        rd_reg(3'b001, 9'h1FE);

        // Asynchronous reset with a pending interrupt
        step_cyc(1'b0);
        exp_irq(2'b01);
        exp_irq(2'b00);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 3'b001, 16'hA000, 1'b0, 1'b0);
        body(14, 0, 0);
        #2 rst = 1'b1;
        #1;
        chk("rst_raster", 32'(raster), 32'h0);
        chk("rst_irq_src", 32'(irq_src), 32'h0);
        chk("rst_cnt_dout", 32'(cnt_dout), 32'h1FF);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) run_line(1'b0, 16, 0, 0);
        rd_reg(3'b001, 9'h1FC);
        rd_reg(3'b100, 9'h1EF);

        repeat (4) cyc(1'b0, 1'b0, 1'b0, 1'b0, '0, 16'h0, 1'b0, 1'b0);
        chk("pending_irq_src_events", 32'(exp_src_q.size()), 32'h0);
        chk("pending_raster_events", 32'(exp_ras_q.size()), 32'h0);
        chk("pending_readbacks", 32'(exp_rd_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
